// File: rtl/bank_multi_if.sv
// Bidder-side bundle of the multi-channel credit bank.
//   master : arbiter/credit source. Drives bid, granted and credit_valid/ch/amt.
//            Observes credit_ready, credit_err, balance, afford and epoch_tick.
//   slave  : the bank. It has the opposite directions.
// CH_W follows max(1, $clog2(N_CH)). It must be the same as the width the bank derives.
interface bank_multi_if #(
    parameter int N_CH  = 4,
    parameter int BID_W = 4,
    parameter int BAL_W = 10,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH*BID_W-1:0] bid;
    logic [N_CH-1:0]       granted;
    logic                  credit_valid;
    logic [CH_W-1:0]       credit_ch;
    logic [BAL_W-1:0]      credit_amt;
    logic                  credit_ready;
    logic                  credit_err;
    logic [N_CH*BAL_W-1:0] balance;
    logic [N_CH-1:0]       afford;
    logic                  epoch_tick;

    modport master (
        output bid, granted, credit_valid, credit_ch, credit_amt,
        input  credit_ready, credit_err, balance, afford, epoch_tick
    );

    modport slave (
        input  bid, granted, credit_valid, credit_ch, credit_amt,
        output credit_ready, credit_err, balance, afford, epoch_tick
    );
endinterface

// File: rtl/bank_multi.sv
// Multi-channel credit bank.
// The bank keeps one saturating balance per bidder channel. When a channel is
// granted, its bid is debited, and the balance never drops below FLOOR. Every
// PERIOD clocks, all channels get a refill capped at CAP. A credit-injection
// port adds an amount to one channel. afford[i] tells the arbiter whether
// channel i can pay its current bid.
// All state updates happen on the FALLING edge of clk, so consumers that sample
// on the rising edge see settled values.
// Ports:
//   clk          clock (state changes on negedge)
//   rst_n        asynchronous active-low reset
//   bus.bid      per-channel bid, channel i in [i*BID_W +: BID_W]
//   bus.granted  grant vector from the arbiter (any number of bits may be set)
//   bus.credit_* credit injection; accepted when valid & ready
//   bus.credit_ready  low only during the epoch-boundary cycle
//   bus.credit_err    one-cycle pulse after an accepted out-of-range credit_ch
//   bus.balance  registered balances, channel i in [i*BAL_W +: BAL_W]
//   bus.afford   combinational: balance[i] >= bid[i] + FLOOR
//   bus.epoch_tick    one-cycle pulse after each refill edge
module bank_multi #(
    parameter int N_CH     = 4,
    parameter int BID_W    = 4,
    parameter int BAL_W    = 10,
    parameter int INIT_BAL = 750,
    parameter int REFILL   = 750,
    parameter int CAP      = 900,
    parameter int FLOOR    = 1,
    parameter int PERIOD   = 401
) (
    input  logic        clk,
    input  logic        rst_n,
    bank_multi_if.slave bus
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(PERIOD);
    // One spare bit, so debit, credit and refill sums never wrap before saturation.
    localparam int EXT_W = BAL_W + 1;
    // A refill larger than CAP always saturates. Clamping it here keeps the
    // refill sum inside EXT_W bits without changing the result.
    localparam int REFILL_EFF = (REFILL > CAP) ? CAP : REFILL;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [EXT_W-1:0] CAP_X    = EXT_W'(CAP);
    localparam logic [EXT_W-1:0] FLOOR_X  = EXT_W'(FLOOR);
    localparam logic [EXT_W-1:0] REFILL_X = EXT_W'(REFILL_EFF);
    localparam logic [BAL_W-1:0] INIT_V   = BAL_W'(INIT_BAL);

    generate
        if (N_CH < 1) begin : g_bad_nch
            $error("bank_multi: N_CH must be >= 1");
        end
        if (PERIOD < 2) begin : g_bad_period
            $error("bank_multi: PERIOD must be >= 2");
        end
        if (CAP >= (1 << BAL_W)) begin : g_bad_cap
            $error("bank_multi: CAP must be < 2**BAL_W");
        end
        if (INIT_BAL > CAP) begin : g_bad_init
            $error("bank_multi: INIT_BAL must be <= CAP");
        end
        if (FLOOR > INIT_BAL) begin : g_bad_floor
            $error("bank_multi: FLOOR must be <= INIT_BAL");
        end
        if (BID_W > BAL_W) begin : g_bad_bid
            $error("bank_multi: BID_W must be <= BAL_W");
        end
    endgenerate

    function automatic logic [BAL_W-1:0] sat_cap(input logic [EXT_W-1:0] v);
        return (v > CAP_X) ? CAP_X[BAL_W-1:0] : v[BAL_W-1:0];
    endfunction

    logic [CNT_W-1:0] epoch_cnt_reg;
    logic [CNT_W-1:0] epoch_cnt_next;
    logic             epoch_tick_reg;
    logic             credit_err_reg;
    logic             credit_err_next;
    logic             boundary;
    logic             credit_fire;

    assign boundary        = (epoch_cnt_reg == CNT_LAST);
    assign epoch_cnt_next  = boundary ? '0 : epoch_cnt_reg + 1'b1;
    assign credit_fire     = bus.credit_valid & ~boundary;
    // An out-of-range channel still consumes the credit. It only raises the error pulse.
    assign credit_err_next = credit_fire & (32'(bus.credit_ch) >= N_CH);

    assign bus.credit_ready = ~boundary;
    assign bus.epoch_tick   = epoch_tick_reg;
    assign bus.credit_err   = credit_err_reg;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch_cnt_reg  <= '0;
            epoch_tick_reg <= 1'b0;
            credit_err_reg <= 1'b0;
        end else begin
            epoch_cnt_reg  <= epoch_cnt_next;
            epoch_tick_reg <= boundary;
            credit_err_reg <= credit_err_next;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [BAL_W-1:0] bal_reg;
        logic [BAL_W-1:0] bal_next;
        logic [EXT_W-1:0] bal_x;
        logic [EXT_W-1:0] bid_x;
        logic [EXT_W-1:0] debit_x;
        logic [EXT_W-1:0] credit_x;
        logic             fits;
        logic             hit;

        assign bal_x = {1'b0, bal_reg};
        assign bid_x = EXT_W'(bus.bid[gi*BID_W +: BID_W]);
        assign fits  = (bal_x >= bid_x + FLOOR_X);

        // If the bid cannot be paid in full, the balance is clamped to FLOOR
        // instead of the grant being refused.
        assign debit_x  = !bus.granted[gi] ? bal_x : (fits ? bal_x - bid_x : FLOOR_X);
        assign hit      = credit_fire & (bus.credit_ch == CH_W'(gi));
        assign credit_x = hit ? debit_x + EXT_W'(bus.credit_amt) : debit_x;
        // On the refill edge, grants and credits are ignored.
        assign bal_next = boundary ? sat_cap(bal_x + REFILL_X) : sat_cap(credit_x);

        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bal_reg <= INIT_V;
            end else begin
                bal_reg <= bal_next;
            end
        end

        assign bus.balance[gi*BAL_W +: BAL_W] = bal_reg;
        assign bus.afford[gi]                 = fits;
    end
endmodule
